// File: rtl/harris_pkg.sv
// Shared definitions for the Harris corner pipeline.
// Pixel/window geometry, counter widths and the window type passed from the
// window generator to the gradient and display stages.
package harris_pkg;

   localparam int PIX_W  = 8;   // pixel width
   localparam int WIN    = 6;   // window edge length
   localparam int GRAD_W = 16;  // gradient sample width
   localparam int CNT_W  = 16;  // window index width

   // window[r][c]: row 0 oldest, column WIN-1 newest
   typedef logic [0:WIN-1][0:WIN-1][PIX_W-1:0] window_t;

endpackage

// File: rtl/line_buffer.sv
// Single-address line buffer RAM.
// One combinational read port and one write port sharing the same address;
// a read in the same cycle as a write returns the old contents.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable
//   addr  - shared read/write address
//   wdata - data written on the rising edge when we=1
//   rdata - current contents at addr
// Contents are deliberately not reset.
module line_buffer #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 40,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/window_buffer.sv
// Streaming 6x6 window generator.
// Accepts a raster-order pixel stream and emits each complete in-image 6x6
// window with a one-cycle strobe, a per-frame window index and an
// end-of-frame strobe. All outputs are registered (1-cycle latency).
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-low reset
//   pix_in     - pixel value
//   pix_valid  - pixel accepted on this edge (no backpressure)
//   sof        - start of frame, qualified by pix_valid; forces (0,0)
//   window     - current 6x6 window, window[r][c]
//   win_valid  - window holds a complete in-image window this cycle
//   count      - 0-based index of the current valid window in the frame
//   frame_done - strobe with the window holding the frame's last pixel
module window_buffer
   import harris_pkg::*;
#(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             sof,
   output window_t          window,
   output logic             win_valid,
   output logic [CNT_W-1:0] count,
   output logic             frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int LBW = (WIN - 1) * PIX_W;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(WIN - 1);
   localparam logic [RW-1:0] ROW_MIN  = RW'(WIN - 1);

   logic [CW-1:0]    col, cur_col;
   logic [RW-1:0]    row, cur_row;
   logic [CNT_W-1:0] idx;
   logic             at_origin, in_win, last_pos;
   logic [LBW-1:0]   lb_rd, lb_wr;
   logic [0:WIN-1][PIX_W-1:0] new_col;

   // sof overrides the stored position so the pixel is handled as (0,0)
   always_comb begin
      cur_col   = sof ? '0 : col;
      cur_row   = sof ? '0 : row;
      at_origin = (cur_col == '0) && (cur_row == '0);
      in_win    = (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
      last_pos  = (row == ROW_LAST) && (col == COL_LAST) && !sof;
   end

   // Five line buffers packed into one RAM word, LB0 in the top byte.
   // Each slot moves up one line; the new pixel enters LB4.
   assign lb_wr = {lb_rd[LBW-PIX_W-1:0], pix_in};

   line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (LBW)
   ) u_lb (
      .clk   (clk),
      .we    (pix_valid),
      .addr  (cur_col),
      .wdata (lb_wr),
      .rdata (lb_rd)
   );

   always_comb begin
      new_col = '0;
      for (int unsigned r = 0; r < WIN - 1; r++) begin
         new_col[r] = lb_rd[(WIN - 2 - r) * PIX_W +: PIX_W];
      end
      new_col[WIN-1] = pix_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col <= '0;
         row <= '0;
      end else if (pix_valid) begin
         if (cur_col == COL_LAST) begin
            col <= '0;
            row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
         end else begin
            col <= cur_col + 1'b1;
            row <= cur_row;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         window <= '0;
      end else if (pix_valid) begin
         for (int unsigned r = 0; r < WIN; r++) begin
            for (int unsigned c = 0; c < WIN - 1; c++) begin
               window[r][c] <= window[r][c+1];
            end
            window[r][WIN-1] <= new_col[r];
         end
      end
   end

   // idx is the index the next valid window will carry; count latches it
   // when that window is emitted so count holds across stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx        <= '0;
         count      <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= pix_valid && in_win;
         frame_done <= pix_valid && last_pos;
         if (pix_valid) begin
            if (in_win) begin
               count <= idx;
               idx   <= idx + 1'b1;
            end else if (at_origin) begin
               count <= '0;
               idx   <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_window_buffer.sv
// Directed testbench for window_buffer on an 8x8 image.
module tb_window_buffer;
   import harris_pkg::*;

   localparam int W = 8;
   localparam int H = 8;

   logic             clk;
   logic             reset;
   logic [PIX_W-1:0] pix_in;
   logic             pix_valid;
   logic             sof;
   window_t          window;
   logic             win_valid;
   logic [CNT_W-1:0] count;
   logic             frame_done;

   int nchk;
   int nerr;
   int exp_cnt;
   int exp_idx;

   window_buffer #(
      .IMG_W (W),
      .IMG_H (H)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .sof        (sof),
      .window     (window),
      .win_valid  (win_valid),
      .count      (count),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Ramp window ending at pixel (r,c): row r-5..r, col c-5..c
   function automatic window_t model_win(input int r, input int c, input int base);
      window_t w;
      for (int i = 0; i < WIN; i++) begin
         for (int j = 0; j < WIN; j++) begin
            w[i][j] = 8'((r - 5 + i) * W + (c - 5 + j) + base);
         end
      end
      return w;
   endfunction

   // Drive one cycle at the falling edge, then sample 1 time unit after the rising edge
   task automatic send(input logic v, input logic [7:0] p, input logic s);
      @(negedge clk);
      pix_valid = v;
      pix_in    = p;
      sof       = s;
      @(posedge clk);
      #1;
   endtask

   task automatic check_pixel(input int r, input int c, input int base, input logic last);
      logic v;
      v = (r >= 5) && (c >= 5);
      if (r == 0 && c == 0) begin
         exp_cnt = 0;
         exp_idx = 0;
      end
      if (v) begin
         exp_cnt = exp_idx;
         exp_idx++;
      end
      chk($sformatf("win_valid(%0d,%0d)", r, c), win_valid, v);
      chk($sformatf("count(%0d,%0d)", r, c), count, exp_cnt);
      chk($sformatf("frame_done(%0d,%0d)", r, c), frame_done, last);
      if (v) chk($sformatf("window(%0d,%0d)", r, c), window, model_win(r, c, base));
   endtask

   task automatic run_frame(input int base, input logic use_sof, input int stall_after);
      int strobes;
      int r;
      int c;
      strobes = 0;
      for (int p = 0; p < W * H; p++) begin
         r = p / W;
         c = p % W;
         send(1'b1, 8'(base + p), use_sof && (p == 0));
         check_pixel(r, c, base, p == W * H - 1);
         if (win_valid === 1'b1) strobes++;
         if (base == 0 && p == 45) begin
            chk("first_win_00", window[0][0], 8'd0);
            chk("first_win_55", window[5][5], 8'd45);
         end
         if (base == 0 && p == 53) begin
            chk("row6_win_00", window[0][0], 8'd8);
            chk("row6_win_55", window[5][5], 8'd53);
            chk("row6_count", count, 16'd3);
         end
         if (base == 0 && p == 63) begin
            chk("last_win_55", window[5][5], 8'd63);
            chk("last_count", count, 16'd8);
         end
         if (p == stall_after) begin
            for (int k = 0; k < 3; k++) begin
               send(1'b0, 8'($urandom_range(0, 255)), 1'b1);
               chk("stall_win_valid", win_valid, 1'b0);
               chk("stall_frame_done", frame_done, 1'b0);
               chk("stall_count", count, exp_cnt);
               chk("stall_window", window, model_win(r, c, base));
            end
         end
      end
      chk("strobes_per_frame", strobes, 9);
   endtask

   task automatic part(input int base, input int n);
      for (int p = 0; p < n; p++) begin
         send(1'b1, 8'(base + p), p == 0);
         check_pixel(p / W, p % W, base, 1'b0);
      end
   endtask

   initial begin
      nchk      = 0;
      nerr      = 0;
      exp_cnt   = 0;
      exp_idx   = 0;
      reset     = 1'b0;
      pix_in    = '0;
      pix_valid = 1'b0;
      sof       = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_window", window, '0);
      chk("rst_win_valid", win_valid, 1'b0);
      chk("rst_count", count, 16'd0);
      chk("rst_frame_done", frame_done, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // ramp frame, then back-to-back frame with stall after (5,6)
      run_frame(0, 1'b1, -1);
      run_frame(100, 1'b1, 46);
      chk("frame2_first_is_100", model_win(5, 5, 100), {8'd100, 280'(0)} | (model_win(5, 5, 100) & {8'h00, {280{1'b1}}}));

      // reset asserted mid-frame at pixel (6,2)
      part(0, 50);
      @(negedge clk);
      pix_valid = 1'b1;
      pix_in    = 8'd50;
      sof       = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_window", window, '0);
      chk("midrst_win_valid", win_valid, 1'b0);
      chk("midrst_count", count, 16'd0);
      chk("midrst_frame_done", frame_done, 1'b0);
      @(negedge clk);
      pix_valid = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
      exp_cnt = 0;
      exp_idx = 0;
      run_frame(0, 1'b0, -1);

      // sof at (2,3) discards the partial frame
      part(0, 19);
      run_frame(0, 1'b1, -1);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
